// File: rtl/mem_dump_pkg.sv
// Shared definitions for the memory dump engine: default widths and FSM state encoding.
// Imported by the RTL and the bench so both agree on sizes and state values.
package mem_dump_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_dump.sv
// Debug readback engine: reads a contiguous word range through a synchronous read port
// and streams each word with its address over valid/ready, holding the core meanwhile.
module mem_dump
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_adr,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              core_hold,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_adr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_adr,
  output logic [2:0]        fsm_state
);

  localparam logic [ADDR_W-1:0] ADR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur_adr;
  logic [ADDR_W-1:0] remaining;

  // Output handshake: a word transfers at a rising edge where out_valid && out_ready.
  // out_valid stays high with out_data/out_adr frozen until that edge (or reset);
  // out_ready while out_valid is low is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = (count != '0) ? S_FETCH : S_DONE;
      S_FETCH:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_SEND;
      S_SEND:    if (out_ready) state_nxt = (remaining == ADR_ONE) ? S_DONE : S_FETCH;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= S_IDLE;
      cur_adr   <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_adr   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start && count != '0) begin
            cur_adr   <= base_adr;
            remaining <= count;
          end
        end
        S_CAPTURE: begin
          out_data <= rd_data;
          out_adr  <= cur_adr;
        end
        S_SEND: begin
          if (out_ready) begin
            remaining <= remaining - ADR_ONE;
            // Advance only if another word follows; wraps modulo 2^ADDR_W.
            if (remaining != ADR_ONE) cur_adr <= cur_adr + ADR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign core_hold = busy;
  assign done      = (state == S_DONE);
  assign rd_en     = (state == S_FETCH);
  assign rd_adr    = rd_en ? cur_adr : '0;
  assign out_valid = (state == S_SEND);
  assign fsm_state = state;

endmodule

// File: tb/tb_mem_dump.sv
// Self-checking bench for mem_dump: behavioural RAM, expected-word scoreboard,
// directed timing cases and randomized dumps with random backpressure.
module tb_mem_dump;
  import mem_dump_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_adr = '0;
  logic [AW-1:0] count = '0;
  logic          busy, core_hold, done, rd_en, out_valid;
  logic [AW-1:0] rd_adr, out_adr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [2:0]    fsm_state;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_adr_q[$];
  logic [AW-1:0] rd_log[$];
  logic [DW-1:0] mem[logic [AW-1:0]];

  mem_dump dut (
    .clk(clk), .res(res), .start(start), .base_adr(base_adr), .count(count),
    .busy(busy), .core_hold(core_hold), .done(done), .rd_en(rd_en), .rd_adr(rd_adr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_adr(out_adr), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural RAM, one-cycle read latency ----------------
  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= mem_rd(rd_adr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  logic          prev_valid = 1'b0;
  logic          prev_hs = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [AW-1:0] prev_adr = '0;

  always @(negedge clk) begin
    if (res) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      chk("core_hold_eq_busy", core_hold, busy);
      if (!rd_en) chk("rd_adr_zero_when_idle", rd_adr, 0);
      else rd_log.push_back(rd_adr);
      if (prev_valid && !prev_hs) begin
        chk("valid_held", out_valid, 1);
        if (out_valid) begin
          chk("data_frozen", out_data, prev_data);
          chk("adr_frozen", out_adr, prev_adr);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got adr %0h data %0h, expected none", out_adr, out_data);
        end else begin
          chk("word_data", out_data, exp_q.pop_front());
          chk("word_adr", out_adr, exp_adr_q.pop_front());
        end
      end
      if (done) chk("done_all_sent", exp_q.size(), 0);
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      prev_data  = out_data;
      prev_adr   = out_adr;
    end
  end

  // ---------------- driver ----------------
  task automatic push_expect(input logic [AW-1:0] base, input logic [AW-1:0] cnt);
    for (int i = 0; i < int'(cnt); i++) begin
      exp_adr_q.push_back(base + AW'(i));
      exp_q.push_back(mem_rd(base + AW'(i)));
    end
  endtask

  // k counts cycles after the edge that samples start: cycle N+k.
  task automatic run_cmd(input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                         input int stall, input bit rnd, input int inj_k,
                         output int fv, output int dk, output int rdn, output int r2,
                         output logic [DW-1:0] fd, output logic [AW-1:0] fa,
                         output int bcyc);
    int k;
    int stalled;
    rd_log.delete();
    push_expect(base, cnt);
    fv = -1; dk = -1; rdn = 0; r2 = -1; fd = '0; fa = '0; bcyc = 0;
    k = 0; stalled = 0;
    @(posedge clk); #1;
    start = 1'b1; base_adr = base; count = cnt;
    out_ready = (stall > 0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    forever begin
      @(negedge clk);
      k++;
      if (busy) bcyc++;
      if (rd_en) begin
        rdn++;
        if (rdn == 2) r2 = k;
      end
      if (out_valid && fv < 0) begin
        fv = k; fd = out_data; fa = out_adr;
      end
      if (out_valid && !out_ready && stalled < stall) stalled++;
      if (done) dk = k;
      if (dk >= 0 || k >= 300) break;
      @(posedge clk); #1;
      out_ready = (stalled < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (k == inj_k) begin
        start = 1'b1; base_adr = 32'd100; count = 32'd5;
      end else begin
        start = 1'b0;
      end
    end
    if (dk < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected a done pulse", k);
    end
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int fv, dk, rdn, r2, bcyc;
  logic [DW-1:0] fd;
  logic [AW-1:0] fa;

  initial begin
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    @(negedge clk);
    chk("reset_state", fsm_state, 0);
    chk("reset_busy", busy, 0);
    chk("reset_core_hold", core_hold, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_rd_adr", rd_adr, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_adr", out_adr, 0);

    // single word
    mem[32'd11] = 32'd27;
    run_cmd(32'd11, 32'd1, 0, 1'b0, -1, fv, dk, rdn, r2, fd, fa, bcyc);
    chk("single_first_valid", fv, 3);
    chk("single_data", fd, 27);
    chk("single_adr", fa, 11);
    chk("single_done", dk, 4);
    chk("single_rd_count", rdn, 1);
    chk("single_rd_adr", rd_log[0], 11);

    // burst
    mem[32'd2] = 32'd5; mem[32'd3] = 32'd12; mem[32'd4] = 32'd15;
    run_cmd(32'd2, 32'd3, 0, 1'b0, -1, fv, dk, rdn, r2, fd, fa, bcyc);
    chk("burst_first_data", fd, 5);
    chk("burst_done", dk, 10);
    chk("burst_rd_count", rdn, 3);
    chk("burst_second_rd", r2, 4);
    chk("burst_busy_cycles", bcyc, 10);

    // backpressure: 4 stall cycles on the first word
    run_cmd(32'd2, 32'd3, 4, 1'b0, -1, fv, dk, rdn, r2, fd, fa, bcyc);
    chk("bp_first_data", fd, 5);
    chk("bp_done", dk, 14);
    chk("bp_second_rd", r2, 8);
    chk("bp_rd_count", rdn, 3);

    // zero count
    run_cmd(32'd7, 32'd0, 0, 1'b0, -1, fv, dk, rdn, r2, fd, fa, bcyc);
    chk("zero_done", dk, 1);
    chk("zero_rd_count", rdn, 0);
    chk("zero_no_valid", fv, -1);
    chk("zero_busy_cycles", bcyc, 1);
    @(negedge clk);
    chk("zero_idle_after", busy, 0);

    // start pulsed mid-burst is ignored
    run_cmd(32'd2, 32'd3, 0, 1'b0, 4, fv, dk, rdn, r2, fd, fa, bcyc);
    chk("inject_done", dk, 10);
    chk("inject_rd_count", rdn, 3);
    @(negedge clk);
    chk("inject_idle_after", busy, 0);

    // address wrap
    run_cmd(32'hFFFF_FFFF, 32'd2, 0, 1'b0, -1, fv, dk, rdn, r2, fd, fa, bcyc);
    chk("wrap_rd0", rd_log[0], 32'hFFFF_FFFF);
    chk("wrap_rd1", rd_log[1], 0);
    chk("wrap_done", dk, 7);

    // reset while in SEND with the word unacknowledged
    push_expect(32'd2, 32'd3);
    @(posedge clk); #1;
    start = 1'b1; base_adr = 32'd2; count = 32'd3; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("rst_reached_send", out_valid, 1);
    @(posedge clk); #1;
    res = 1'b1;
    exp_q.delete();
    exp_adr_q.delete();
    @(posedge clk); #1;
    res = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_hold", core_hold, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    chk("rst_no_late_done", done, 0);
    run_cmd(32'd2, 32'd3, 0, 1'b0, -1, fv, dk, rdn, r2, fd, fa, bcyc);
    chk("post_rst_done", dk, 10);
    chk("post_rst_data", fd, 5);

    // randomized dumps
    for (int it = 0; it < 24; it++) begin
      logic [AW-1:0] b;
      logic [AW-1:0] c;
      bit rnd;
      b = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - AW'($urandom_range(0, 3))) : AW'($urandom);
      c = AW'($urandom_range(1, 6));
      rnd = 1'($urandom_range(0, 1));
      run_cmd(b, c, 0, rnd, -1, fv, dk, rdn, r2, fd, fa, bcyc);
      chk("rand_rd_count", rdn, c);
      chk("rand_first_adr", fa, b);
      chk("rand_queue_empty", exp_q.size(), 0);
      if (!rnd) chk("rand_done_time", dk, 3 * int'(c) + 1);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
